// File: rtl/watch_timekeeper.sv
// rtl/watch_timekeeper.sv - watch timekeeper with run/set FSM, prescaler, alarm and 12/24h display
// Time runs only in RUN; SET states edit one field at a time with no carry.
module watch_timekeeper #(
  parameter int TICK_DIV = 1,
  parameter int PRESC_W  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stop_run,
  input  logic       next,
  input  logic       inc,
  input  logic       dec,
  input  logic       alarm_sel,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  input  logic       mode12,
  output logic [4:0] hrs,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [4:0] disp_hrs,
  output logic       pm,
  output logic [4:0] al_hrs,
  output logic [5:0] al_min,
  output logic       alarm_hit,
  output logic [1:0] state
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HSET = 2'd1;
  localparam logic [1:0] ST_MSET = 2'd2;
  localparam logic [1:0] ST_SSET = 2'd3;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [1:0]         state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [4:0]         hrs_q, hrs_d, al_hrs_q, al_hrs_d;
  logic [5:0]         min_q, min_d, sec_q, sec_d, al_min_q, al_min_d;
  logic               hit_q, hit_d;
  logic               tick;
  logic               edit_en;

  // Wrapping +/-1 on a field whose legal range is 0..top.
  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] top,
                                            input logic up);
    logic [5:0] r;
    if (up) r = (v == top) ? 6'd0 : v + 6'd1;
    else    r = (v == 6'd0) ? top : v - 6'd1;
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    hrs_d    = hrs_q;
    min_d    = min_q;
    sec_d    = sec_q;
    al_hrs_d = al_hrs_q;
    al_min_d = al_min_q;
    hit_d    = hit_q;
    tick     = 1'b0;
    edit_en  = (state_q != ST_RUN) && !next && !stop_run && (inc ^ dec);

    if (state_q == ST_RUN) begin
      if (stop_run) begin
        state_d = ST_HSET;
        presc_d = '0;
      end else if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end else begin
      presc_d = '0;
      if (stop_run)  state_d = ST_RUN;
      else if (next) state_d = (state_q == ST_SSET) ? ST_HSET : state_q + 2'd1;
    end

    if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          hrs_d = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (edit_en) begin
      case (state_q)
        ST_HSET: begin
          if (alarm_sel) al_hrs_d = 5'(step_field({1'b0, al_hrs_q}, 6'd23, inc));
          else           hrs_d    = 5'(step_field({1'b0, hrs_q}, 6'd23, inc));
        end
        ST_MSET: begin
          if (alarm_sel) al_min_d = step_field(al_min_q, 6'd59, inc);
          else           min_d    = step_field(min_q, 6'd59, inc);
        end
        ST_SSET: begin
          if (!alarm_sel) sec_d = step_field(sec_q, 6'd59, inc);
        end
        default: ;
      endcase
    end

    // A new alarm match wins over a same-cycle acknowledge.
    if (tick && alarm_en && hrs_d == al_hrs_q && min_d == al_min_q && sec_d == 6'd0)
      hit_d = 1'b1;
    else if (alarm_ack)
      hit_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      presc_q  <= '0;
      hrs_q    <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      al_hrs_q <= '0;
      al_min_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      hrs_q    <= hrs_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      al_hrs_q <= al_hrs_d;
      al_min_q <= al_min_d;
      hit_q    <= hit_d;
    end
  end

  always_comb begin
    disp_hrs = hrs_q;
    if (mode12) begin
      if (hrs_q == 5'd0)      disp_hrs = 5'd12;
      else if (hrs_q > 5'd12) disp_hrs = hrs_q - 5'd12;
    end
  end

  assign pm        = (hrs_q >= 5'd12);
  assign hrs       = hrs_q;
  assign min       = min_q;
  assign sec       = sec_q;
  assign al_hrs    = al_hrs_q;
  assign al_min    = al_min_q;
  assign alarm_hit = hit_q;
  assign state     = state_q;

endmodule

// File: tb/tb_watch_timekeeper.sv
// tb/tb_watch_timekeeper.sv - scoreboard bench for watch_timekeeper (TICK_DIV=1 and TICK_DIV=4 instances)
// A seconds-of-day reference model predicts outputs; a monitor compares after each edge.
module tb_watch_timekeeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stop_run = 0, next = 0, inc = 0, dec = 0;
  logic alarm_sel = 0, alarm_en = 0, alarm_ack = 0, mode12 = 0;

  logic [4:0] a_hrs, a_disp, a_alh, b_hrs, b_disp, b_alh;
  logic [5:0] a_min, a_sec, a_alm, b_min, b_sec, b_alm;
  logic       a_pm, a_hit, b_pm, b_hit;
  logic [1:0] a_st, b_st;

  always #5 clk = ~clk;

  watch_timekeeper #(.TICK_DIV(1), .PRESC_W(24)) u_dut1 (
    .clk(clk), .rst(rst), .stop_run(stop_run), .next(next), .inc(inc), .dec(dec),
    .alarm_sel(alarm_sel), .alarm_en(alarm_en), .alarm_ack(alarm_ack), .mode12(mode12),
    .hrs(a_hrs), .min(a_min), .sec(a_sec), .disp_hrs(a_disp), .pm(a_pm),
    .al_hrs(a_alh), .al_min(a_alm), .alarm_hit(a_hit), .state(a_st));

  watch_timekeeper #(.TICK_DIV(4), .PRESC_W(24)) u_dut4 (
    .clk(clk), .rst(rst), .stop_run(stop_run), .next(next), .inc(inc), .dec(dec),
    .alarm_sel(alarm_sel), .alarm_en(alarm_en), .alarm_ack(alarm_ack), .mode12(mode12),
    .hrs(b_hrs), .min(b_min), .sec(b_sec), .disp_hrs(b_disp), .pm(b_pm),
    .al_hrs(b_alh), .al_min(b_alm), .alarm_hit(b_hit), .state(b_st));

  typedef struct {
    int st; int presc; int h; int m; int s; int ah; int am; bit hit;
  } mdl_t;

  typedef struct {
    mdl_t a; mdl_t b; bit m12;
  } exp_t;

  exp_t exp_q[$];
  mdl_t ma, mb;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.st = 0; r.presc = 0; r.h = 0; r.m = 0; r.s = 0; r.ah = 0; r.am = 0; r.hit = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int div, bit sr, bit nx, bit in, bit de,
                                 bit sel, bit en, bit ack);
    mdl_t r = m;
    bit   fire = 0;
    int   tod, d;
    if (m.st == 0) begin
      if (sr) begin
        r.st = 1; r.presc = 0;
      end else if (m.presc == div - 1) begin
        r.presc = 0;
        tod = (m.h * 3600 + m.m * 60 + m.s + 1) % 86400;
        r.h = tod / 3600; r.m = (tod / 60) % 60; r.s = tod % 60;
        fire = en && (tod == m.ah * 3600 + m.am * 60);
      end else begin
        r.presc = m.presc + 1;
      end
    end else begin
      r.presc = 0;
      if (sr) r.st = 0;
      else if (nx) r.st = (m.st == 3) ? 1 : m.st + 1;
      else if (in != de) begin
        d = in ? 1 : -1;
        if (m.st == 1) begin
          if (sel) r.ah = (m.ah + d + 24) % 24; else r.h = (m.h + d + 24) % 24;
        end else if (m.st == 2) begin
          if (sel) r.am = (m.am + d + 60) % 60; else r.m = (m.m + d + 60) % 60;
        end else if (!sel) begin
          r.s = (m.s + d + 60) % 60;
        end
      end
    end
    if (fire) r.hit = 1; else if (ack) r.hit = 0;
    return r;
  endfunction

  function automatic int disp_of(int h, bit m12);
    if (!m12) return h;
    return (h % 12 == 0) ? 12 : h % 12;
  endfunction

  task automatic chk(string name, int act, int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_dut(string tag, int st, int h, int m, int s, int dh, int p,
                         int ah, int am, int hit, mdl_t e, bit m12);
    chk({tag, ".state"}, st, e.st);
    chk({tag, ".hrs"}, h, e.h);
    chk({tag, ".min"}, m, e.m);
    chk({tag, ".sec"}, s, e.s);
    chk({tag, ".disp_hrs"}, dh, disp_of(e.h, m12));
    chk({tag, ".pm"}, p, (e.h >= 12) ? 1 : 0);
    chk({tag, ".al_hrs"}, ah, e.ah);
    chk({tag, ".al_min"}, am, e.am);
    chk({tag, ".alarm_hit"}, hit, int'(e.hit));
  endtask

  // Monitor: one expectation per rising edge, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_dut("d1", a_st, a_hrs, a_min, a_sec, a_disp, a_pm, a_alh, a_alm, a_hit, e.a, e.m12);
        chk_dut("d4", b_st, b_hrs, b_min, b_sec, b_disp, b_pm, b_alh, b_alm, b_hit, e.b, e.m12);
      end
    end
  end

  // Called at a falling edge: drive inputs, predict, then wait for the next falling edge.
  task automatic cyc(bit sr, bit nx, bit in, bit de, bit sel, bit ack);
    exp_t e;
    stop_run = sr; next = nx; inc = in; dec = de; alarm_sel = sel; alarm_ack = ack;
    ma = mstep(ma, 1, sr, nx, in, de, sel, alarm_en, ack);
    mb = mstep(mb, 4, sr, nx, in, de, sel, alarm_en, ack);
    e.a = ma; e.b = mb; e.m12 = mode12;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, " d1.state"}, a_st, 0);
    chk({tag, " d1.time"}, {a_hrs, a_min, a_sec}, 0);
    chk({tag, " d1.alarm"}, {a_alh, a_alm, a_hit}, 0);
    chk({tag, " d4.state"}, b_st, 0);
    chk({tag, " d4.time"}, {b_hrs, b_min, b_sec}, 0);
    chk({tag, " d4.alarm"}, {b_alh, b_alm, b_hit}, 0);
  endtask

  initial begin
    ma = mdl_reset();
    mb = mdl_reset();
    #1;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Prescaling: 12 free-running cycles, then stop and hold.
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);

    // Wrap edits in HSET, then build 23:59:59 for the rollover.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 64 && ma.s != 59; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);

    // Alarm at 07:30, time preset to 07:29:59.
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30 && ma.ah != 7; i++) cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 64 && ma.am != 30; i++) cyc(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 64 && ma.m != 29; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 64 && ma.s != 59; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 30 && ma.h != 7; i++) cyc(0, 0, 1, 0, 0, 0);
    alarm_en = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    alarm_en = 1'b0;

    // 12-hour display at 13, 0 and 12 o'clock.
    mode12 = 1'b1;
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30 && ma.h != 13; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30 && ma.h != 0; i++) cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 30 && ma.h != 12; i++) cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      alarm_en = 1'($urandom_range(0, 1));
      mode12   = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // Reset while in MSET with an edit pending.
    if (ma.st != 0) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, (i % 2) == 1, 0);
    inc = 1'b1;
    stop_run = 1'b0; next = 1'b0; dec = 1'b0;
    rst = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(negedge clk);
    chk_zero("held_reset");
    ma = mdl_reset();
    mb = mdl_reset();
    rst = 1'b1;
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/watch_timekeeper.md
WATCH_TIMEKEEPER -- requirements
Module: watch_timekeeper

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1, meaning clk cycles per one-second tick (legal range 1 to 2^24).
REQ-002 SHALL have parameter PRESC_W, default 24, meaning prescaler counter width (must hold TICK_DIV-1).
REQ-003 SHALL have port clk, input, 1, meaning the single clock (all state updates on rising edge).
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port stop_run, input, 1, meaning run/set toggle request, sampled per cycle.
REQ-006 SHALL have port next, input, 1, meaning advance to next edit field.
REQ-007 SHALL have ports inc and dec, each input, 1, meaning field increment / decrement.
REQ-008 SHALL have port alarm_sel, input, 1, meaning edit target: 0 is time, 1 is alarm.
REQ-009 SHALL have port alarm_en, input, 1, meaning alarm compare enable.
REQ-010 SHALL have port alarm_ack, input, 1, meaning clear alarm_hit.
REQ-011 SHALL have port mode12, input, 1, meaning display format: 1 is 12-hour, 0 is 24-hour.
REQ-012 SHALL have outputs hrs (output, 5, internal hours 0..23), min (output, 6, minutes) and sec (output, 6, seconds).
REQ-013 SHALL have port disp_hrs, output, 5, meaning formatted display hours.
REQ-014 SHALL have port pm, output, 1, meaning hrs >= 12.
REQ-015 SHALL have outputs al_hrs (output, 5) and al_min (output, 6), meaning alarm time registers.
REQ-016 SHALL have port alarm_hit, output, 1, meaning latched alarm flag.
REQ-017 SHALL have port state, output, 2, meaning current mode encoded as RUN=0, HSET=1, MSET=2, SSET=3.

Function
REQ-018 SHALL implement FSM transitions: RUN + stop_run -> HSET; in any SET state, stop_run -> RUN; otherwise next steps HSET -> MSET -> SSET -> HSET.
REQ-019 SHALL give stop_run priority over next in every SET state.
REQ-020 SHALL, in RUN, count the prescaler 0..TICK_DIV-1 and assert an internal tick on the cycle where prescaler == TICK_DIV-1; with TICK_DIV=1, tick fires every cycle.
REQ-021 SHALL, on tick, advance sec 59->0 with carry to min, and min 59->0 with carry to hrs, with hrs wrapping 23->0.
REQ-022 SHALL clear the prescaler on every state transition, so the first post-set tick occurs TICK_DIV cycles after re-entering RUN.
REQ-023 SHALL NOT advance time, and SHALL hold the prescaler at 0, in any SET state.
REQ-024 SHALL NOT advance time in the RUN cycle in which stop_run is sampled.
REQ-025 SHALL, in a SET state, edit the selected field by +1 when inc=1 and dec=0, and by -1 when inc=0 and dec=1; inc=dec gives no change.
REQ-026 SHALL wrap edits both ways: sec/min 59<->0, hrs and al_hrs 23<->0; edits never carry into neighbouring fields.
REQ-027 SHALL suppress all edits in any cycle where next=1 or stop_run=1.
REQ-028 SHALL select the edit target with alarm_sel, sampled each cycle: HSET edits hrs or al_hrs, MSET edits min or al_min.
REQ-029 SHALL make SSET with alarm_sel=1 edit nothing (the alarm has no seconds field).
REQ-030 SHALL, in SSET, have edits to sec leave the prescaler unaffected.
REQ-031 SHALL set alarm_hit on the cycle a RUN tick produces hrs:min:sec == al_hrs:al_min:00 with alarm_en=1.
REQ-032 SHALL keep alarm_hit set until alarm_ack=1; a simultaneous set and ack results in alarm_hit=1.
REQ-033 SHALL NOT trigger alarm_hit from time edits made in SET states.
REQ-034 SHALL compute disp_hrs combinationally from hrs: when mode12=0, disp_hrs = hrs; when mode12=1, hrs 0 -> 12, 1..12 -> hrs, 13..23 -> hrs-12.
REQ-035 SHALL compute pm combinationally as hrs >= 12, independent of mode12.

Reset
REQ-036 SHALL, while rst=0, asynchronously force state=RUN, prescaler=0, hrs=min=sec=0, al_hrs=al_min=0 and alarm_hit=0.
REQ-037 SHALL, after rst is released, make the first tick occur TICK_DIV rising edges later.
REQ-038 SHALL, when reset is asserted mid-SET, return the FSM to RUN with no pending edit applied.

Verification
REQ-039 SHALL verify rollover: preload 23:59:59 in RUN, TICK_DIV=1, one cycle -> 00:00:00, pm=0.
REQ-040 SHALL verify prescaling: TICK_DIV=4 from reset -> sec=1 after 4 cycles and sec=3 after 12 cycles; stop_run pulse -> HSET and sec frozen.
REQ-041 SHALL verify wrap edits: in HSET with hrs=0 apply dec -> hrs=23; with inc=dec=1 -> hrs unchanged; with next+inc -> MSET and hrs unchanged.
REQ-042 SHALL verify the alarm: set al_hrs=7, al_min=30 via alarm_sel=1, run from 07:29:59 with alarm_en=1 -> alarm_hit=1 after one tick, held until alarm_ack.
REQ-043 SHALL verify 12-hour display: hrs=13 with mode12=1 -> disp_hrs=1, pm=1; hrs=0 -> disp_hrs=12, pm=0; hrs=12 -> disp_hrs=12, pm=1.
REQ-044 SHALL verify reset mid-operation: in MSET assert rst=0 with inc=1 -> immediately state=RUN and all time and alarm registers 0.
